// File: rtl/apb_master_bridge_if.sv
// CPU request/response bus and APB3 bus as seen by the APB master bridge.
// master = the bridge itself, slave = the CPU plus the APB peripherals around it.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_addr_ok;
    logic              cpu_data_ok;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;

    logic              apb_psel;
    logic              apb_penable;
    logic              apb_pwrite;
    logic [ADDR_W-1:0] apb_paddr;
    logic [DATA_W-1:0] apb_pwdata;
    logic [DATA_W-1:0] apb_prdata;
    logic              apb_pready;
    logic              apb_pslverr;

    modport master (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  apb_prdata, apb_pready, apb_pslverr,
        output cpu_addr_ok, cpu_data_ok, cpu_rdata, cpu_err,
        output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata
    );

    modport slave (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output apb_prdata, apb_pready, apb_pslverr,
        input  cpu_addr_ok, cpu_data_ok, cpu_rdata, cpu_err,
        input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding CPU bus to APB3 master bridge with an optional pready timeout.
// One transfer takes IDLE -> SETUP -> ACCESS (1..TIMEOUT cycles) -> RESP.
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 apb_pclk,
    input  logic                 apb_prstn,
    apb_master_bridge_if.master  bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state_q, state_d;
    req_t              hold_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              accept;
    logic              tmo_hit;

    // addr_ok is gated by reset so no acceptance is visible while the bridge is held in reset
    assign accept  = apb_prstn && (state_q == IDLE) && bus.cpu_req;
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cpu_req) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (bus.apb_pready || tmo_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            hold_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept)
                hold_q <= '{wr: bus.cpu_wr, addr: bus.cpu_addr & ~ADDR_W'(3), wdata: bus.cpu_wdata};
            case (state_q)
                ACCESS: begin
                    cnt_q <= cnt_q + 1'b1;
                    // pready wins over a timeout landing on the same cycle
                    if (bus.apb_pready) begin
                        rdata_q <= hold_q.wr ? '0 : bus.apb_prdata;
                        err_q   <= bus.apb_pslverr;
                    end else if (tmo_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                RESP:    cnt_q <= '0;
                default: ;
            endcase
        end
    end

    assign bus.cpu_addr_ok = accept;
    assign bus.cpu_data_ok = (state_q == RESP);
    assign bus.cpu_rdata   = rdata_q;
    assign bus.cpu_err     = err_q;
    assign bus.apb_psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.apb_penable = (state_q == ACCESS);
    assign bus.apb_pwrite  = hold_q.wr;
    assign bus.apb_paddr   = hold_q.addr;
    assign bus.apb_pwdata  = hold_q.wdata;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: zero-wait, wait-state, timeout, back-to-back and reset cases.
module tb_apb_master_bridge;
    localparam int TO = 16;

    logic clk;
    logic rstn;
    int   n_chk  = 0;
    int   n_fail = 0;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .apb_pclk  (clk),
        .apb_prstn (rstn),
        .bus       (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // One isolated transfer; pready rises after 'waits' ACCESS cycles unless the timeout fires first.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits,
                        input logic [31:0] prd, input logic slverr);
        bit          to;
        int          acc, rc, pen, stray;
        logic [31:0] exp_rd;
        logic        exp_err;
        to      = (TO != 0) && (waits >= TO);
        acc     = to ? TO : waits + 1;
        rc      = 2 + acc;
        exp_rd  = (to || wr) ? 32'h0 : prd;
        exp_err = to ? 1'b1 : slverr;
        pen     = 0;
        stray   = 0;
        bus.cpu_req   = 1'b1;
        bus.cpu_wr    = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        for (int c = 0; c <= rc + 1; c++) begin
            bus.apb_pready  = (c >= 2) && (c - 2 >= waits);
            bus.apb_prdata  = bus.apb_pready ? prd : 32'hDEAD_BEEF;
            bus.apb_pslverr = bus.apb_pready && slverr;
            @(negedge clk);
            if (bus.apb_penable) pen++;
            if (c != rc && bus.cpu_data_ok) stray++;
            if (c == 0) chk({tag, ".addr_ok"}, 32'(bus.cpu_addr_ok), 32'(1));
            if (c == 1) begin
                chk({tag, ".setup_psel"},    32'(bus.apb_psel),    32'(1));
                chk({tag, ".setup_penable"}, 32'(bus.apb_penable), 32'(0));
                chk({tag, ".paddr"},         bus.apb_paddr,        addr & 32'hFFFF_FFFC);
                chk({tag, ".pwrite"},        32'(bus.apb_pwrite),  32'(wr));
                if (wr) chk({tag, ".pwdata"}, bus.apb_pwdata, wdata);
            end
            if (c == 2) chk({tag, ".access_psel"}, 32'(bus.apb_psel), 32'(1));
            if (c == rc) begin
                chk({tag, ".data_ok"},   32'(bus.cpu_data_ok), 32'(1));
                chk({tag, ".rdata"},     bus.cpu_rdata,        exp_rd);
                chk({tag, ".err"},       32'(bus.cpu_err),     32'(exp_err));
                chk({tag, ".resp_psel"}, 32'(bus.apb_psel),    32'(0));
            end
            if (c == rc + 1) begin
                chk({tag, ".idle_psel"},    32'(bus.apb_psel),    32'(0));
                chk({tag, ".idle_addr_ok"}, 32'(bus.cpu_addr_ok), 32'(0));
            end
            next_cyc();
            if (c == 0) bus.cpu_req = 1'b0;
        end
        chk({tag, ".penable_cycles"}, 32'(pen),   32'(acc));
        chk({tag, ".stray_data_ok"},  32'(stray), 32'(0));
        bus.apb_pready  = 1'b0;
        bus.apb_pslverr = 1'b0;
    endtask

    logic [31:0] b2b_addr [3];

    initial begin
        rstn            = 1'b0;
        bus.cpu_req     = 1'b0;
        bus.cpu_wr      = 1'b0;
        bus.cpu_addr    = '0;
        bus.cpu_wdata   = '0;
        bus.apb_prdata  = '0;
        bus.apb_pready  = 1'b0;
        bus.apb_pslverr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.psel",    32'(bus.apb_psel),    32'(0));
        chk("rst.penable", 32'(bus.apb_penable), 32'(0));
        chk("rst.pwrite",  32'(bus.apb_pwrite),  32'(0));
        chk("rst.paddr",   bus.apb_paddr,        32'h0);
        chk("rst.pwdata",  bus.apb_pwdata,       32'h0);
        chk("rst.data_ok", 32'(bus.cpu_data_ok), 32'(0));
        chk("rst.rdata",   bus.cpu_rdata,        32'h0);
        chk("rst.err",     32'(bus.cpu_err),     32'(0));
        next_cyc();
        rstn = 1'b1;
        next_cyc();

        xfer("wr0",  1'b1, 32'hBF00_1044, 32'h0010_0000, 0,  32'h0,         1'b0);
        xfer("rd0",  1'b0, 32'h0000_0048, 32'h0,         0,  32'hA5A5_0002, 1'b0);
        xfer("rdw",  1'b0, 32'h0000_0100, 32'h0,         3,  32'h1234_5678, 1'b0);
        // pready arrives in the RESP cycle, after the timeout already fired
        xfer("tmo",  1'b0, 32'h0000_0200, 32'h0,         TO, 32'h5555_AAAA, 1'b0);
        xfer("post", 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 0,  32'h0,         1'b0);
        xfer("wrer", 1'b1, 32'h0000_0208, 32'h0000_0001, 1,  32'h0,         1'b1);

        // Back-to-back reads with req held high
        b2b_addr[0] = 32'hBF00_0047;
        b2b_addr[1] = 32'hBF00_0050;
        b2b_addr[2] = 32'hBF00_0058;
        begin
            int k;
            k = 0;
            bus.cpu_req  = 1'b1;
            bus.cpu_wr   = 1'b0;
            bus.cpu_addr = b2b_addr[0];
            for (int c = 0; c < 12; c++) begin
                bus.apb_pready  = 1'b1;
                bus.apb_prdata  = 32'hC0DE_0000 + 32'(c);
                bus.apb_pslverr = (c == 6);
                @(negedge clk);
                chk($sformatf("b2b.addr_ok%0d", c), 32'(bus.cpu_addr_ok),
                    32'((c % 4 == 0) && (c <= 8)));
                if (c % 4 == 1)
                    chk($sformatf("b2b.paddr%0d", c), bus.apb_paddr, b2b_addr[c / 4] & 32'hFFFF_FFFC);
                if (c % 4 == 3) begin
                    chk($sformatf("b2b.data_ok%0d", c), 32'(bus.cpu_data_ok), 32'(1));
                    chk($sformatf("b2b.rdata%0d", c),   bus.cpu_rdata, 32'hC0DE_0000 + 32'(c - 1));
                    chk($sformatf("b2b.err%0d", c),     32'(bus.cpu_err), 32'(c == 7));
                end
                next_cyc();
                if (c % 4 == 0) begin
                    k++;
                    if (k < 3) bus.cpu_addr = b2b_addr[k];
                    else       bus.cpu_req  = 1'b0;
                end
            end
            bus.apb_pready  = 1'b0;
            bus.apb_pslverr = 1'b0;
        end

        // Reset during a wait-stated read; req stays high throughout
        bus.cpu_req  = 1'b1;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = 32'h0000_0300;
        next_cyc();
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk("rstmid.pre_penable", 32'(bus.apb_penable), 32'(1));
        #2 rstn = 1'b0;
        #1;
        chk("rstmid.psel",    32'(bus.apb_psel),    32'(0));
        chk("rstmid.penable", 32'(bus.apb_penable), 32'(0));
        chk("rstmid.data_ok", 32'(bus.cpu_data_ok), 32'(0));
        chk("rstmid.addr_ok", 32'(bus.cpu_addr_ok), 32'(0));
        chk("rstmid.paddr",   bus.apb_paddr,        32'h0);
        next_cyc();
        next_cyc();
        rstn = 1'b1;
        @(negedge clk);
        chk("rstrel.addr_ok_hi", 32'(bus.cpu_addr_ok), 32'(1));
        chk("rstrel.psel",       32'(bus.apb_psel),    32'(0));
        bus.cpu_req = 1'b0;
        #1;
        chk("rstrel.addr_ok_lo", 32'(bus.cpu_addr_ok), 32'(0));
        next_cyc();
        xfer("rec", 1'b0, 32'h0000_0304, 32'h0, 2, 32'h0BAD_CAFE, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
